// File: rtl/cast_credit_tx_pkg.sv
// Shared constants and types for the cast credit transmitter.
// Flit layout: [DW-1:DW-2] flit type, [DW-3:0] payload.
package cast_credit_tx_pkg;

  localparam int DW               = 18;      // flit width
  localparam int PW               = DW - 2;  // payload width
  localparam int PKT_LEN_DEF      = 4;       // flits per packet incl. HEAD and TAIL
  localparam int BUFFER_ALLOC     = 4;       // receiver FIFO depth
  localparam int BUFFER_ALLOC_LOG = 2;
  localparam int SID_W            = 10;      // header stream-id field width

  typedef enum logic [1:0] {
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_HEAD  = 2'b01,
    S_PAYLD = 2'b10
  } tx_state_e;

endpackage

// File: rtl/cast_credit_tx_credit_counter.sv
// Credit counter for the cast transmitter.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   inc        one credit returned by the receiver
//   dec        one credit spent on a flit send
//   cnt        current credit count (resets to CREDITS)
//   nz         cnt != 0
//   err        sticky: a credit came back while already at CREDITS
module credit_counter #(
  parameter int CRD_W   = 3,
  parameter int CREDITS = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             dec,
  output logic [CRD_W-1:0] cnt,
  output logic             nz,
  output logic             err
);

  localparam logic [CRD_W-1:0] MAX_CRD = CRD_W'(CREDITS);

  logic [CRD_W-1:0] r_cnt;
  logic             r_err;
  logic             w_sat;

  // A lone return at full count is a protocol error: hold the count, flag it.
  assign w_sat = inc & ~dec & (r_cnt == MAX_CRD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= MAX_CRD;
      r_err <= 1'b0;
    end else begin
      if (w_sat) begin
        r_err <= 1'b1;
      end else if (inc & ~dec) begin
        r_cnt <= r_cnt + CRD_W'(1);
      end else if (dec & ~inc) begin
        r_cnt <= r_cnt - CRD_W'(1);
      end
    end
  end

  assign cnt = r_cnt;
  assign nz  = (r_cnt != '0);
  assign err = r_err;

endmodule

// File: rtl/cast_credit_tx.sv
// Credit-based packet transmitter on the cast network. Wraps upstream payload
// words into packets of PKT_LEN flits (HEAD, BODY..., TAIL) and sends a flit
// only while a receiver FIFO credit is held.
// Ports:
//   clk, rstn     clock, asynchronous active-low reset
//   valid_i       upstream payload word valid
//   data_i        upstream payload word
//   ready_o       payload word accepted this cycle
//   valid_o_cast  flit valid toward receiver
//   data_o_cast   flit {type, payload}
//   ready_i_cast  receiver ready
//   credit_upd    one receiver FIFO slot freed (1-cycle pulse)
//   credit_cnt    current credit count
//   pkt_done      registered pulse the cycle after a TAIL handshake
//   credit_err    sticky credit overflow flag
module cast_credit_tx
  import cast_credit_tx_pkg::*;
#(
  parameter logic [SID_W-1:0] stream_id = 10'd0,
  parameter int               PKT_LEN   = PKT_LEN_DEF,
  parameter int               CREDITS   = BUFFER_ALLOC,
  parameter int               CRD_W     = BUFFER_ALLOC_LOG + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_i,
  input  logic [PW-1:0]    data_i,
  output logic             ready_o,
  output logic             valid_o_cast,
  output logic [DW-1:0]    data_o_cast,
  input  logic             ready_i_cast,
  input  logic             credit_upd,
  output logic [CRD_W-1:0] credit_cnt,
  output logic             pkt_done,
  output logic             credit_err
);

  localparam int FC_W = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] HEAD_PAYLOAD = {{(PW-SID_W){1'b0}}, stream_id};

  tx_state_e       r_state;
  tx_state_e       w_next_state;
  logic [FC_W-1:0] r_flit_cnt;
  logic [FC_W-1:0] w_next_flit_cnt;
  logic            r_pkt_done;
  logic            w_send;
  logic            w_tail_sent;
  logic            w_is_tail;
  logic            w_crd_nz;
  logic [1:0]      w_ftype;

  credit_counter #(
    .CRD_W   (CRD_W),
    .CREDITS (CREDITS)
  ) u_credit_counter (
    .clk  (clk),
    .rstn (rstn),
    .inc  (credit_upd),
    .dec  (w_send),
    .cnt  (credit_cnt),
    .nz   (w_crd_nz),
    .err  (credit_err)
  );

  assign w_is_tail = (r_flit_cnt == FC_W'(PKT_LEN - 1));
  assign w_ftype   = w_is_tail ? FLIT_TAIL : FLIT_BODY;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_flit_cnt <= '0;
      r_pkt_done <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_flit_cnt <= w_next_flit_cnt;
      r_pkt_done <= w_tail_sent;
    end
  end

  always_comb begin
    w_next_state    = r_state;
    w_next_flit_cnt = r_flit_cnt;
    valid_o_cast    = 1'b0;
    ready_o         = 1'b0;
    w_send          = 1'b0;
    w_tail_sent     = 1'b0;
    data_o_cast     = {FLIT_HEAD, HEAD_PAYLOAD};
    case (r_state)
      S_IDLE: begin
        // The pending word only opens the packet; it is consumed in PAYLD.
        if (valid_i) w_next_state = S_HEAD;
      end
      S_HEAD: begin
        valid_o_cast = w_crd_nz;
        w_send       = w_crd_nz & ready_i_cast;
        if (w_send) begin
          w_next_state    = S_PAYLD;
          w_next_flit_cnt = FC_W'(1);
        end
      end
      S_PAYLD: begin
        // Payload passes straight through; the word is accepted exactly
        // when its flit is handshaked.
        valid_o_cast = valid_i & w_crd_nz;
        w_send       = valid_o_cast & ready_i_cast;
        ready_o      = w_send;
        data_o_cast  = {w_ftype, data_i};
        if (w_send) begin
          if (w_is_tail) begin
            w_next_flit_cnt = '0;
            w_tail_sent     = 1'b1;
            w_next_state    = valid_i ? S_HEAD : S_IDLE;
          end else begin
            w_next_flit_cnt = r_flit_cnt + FC_W'(1);
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign pkt_done = r_pkt_done;

endmodule

// File: tb/tb_cast_credit_tx.sv
module tb_cast_credit_tx;
  import cast_credit_tx_pkg::*;

  localparam int         PL  = 4;
  localparam int         CR  = 4;
  localparam int         CW  = 3;
  localparam logic [9:0] SID = 10'h2A;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          valid_i = 1'b0;
  logic [PW-1:0] data_i = '0;
  logic          ready_o;
  logic          valid_o_cast;
  logic [DW-1:0] data_o_cast;
  logic          ready_i_cast = 1'b0;
  logic          credit_upd = 1'b0;
  logic [CW-1:0] credit_cnt;
  logic          pkt_done;
  logic          credit_err;

  always #5 clk = ~clk;

  cast_credit_tx #(
    .stream_id (SID),
    .PKT_LEN   (PL),
    .CREDITS   (CR),
    .CRD_W     (CW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .valid_o_cast (valid_o_cast),
    .data_o_cast  (data_o_cast),
    .ready_i_cast (ready_i_cast),
    .credit_upd   (credit_upd),
    .credit_cnt   (credit_cnt),
    .pkt_done     (pkt_done),
    .credit_err   (credit_err)
  );

  int n_chk = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Scoreboard: words issued by the driver, in issue order.
  logic [31:0] wq[$];

  // Reference model state (packet position, credits, flags).
  int            m_cred = CR;
  bit            m_err = 1'b0;
  int            m_pos = 0;
  bit            exp_done = 1'b0;
  bit            prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            n_send = 0;
  int            n_acc = 0;
  int            n_tail = 0;
  int            streak = 0;
  int            tail_streak = 0;
  bit            want_first = 1'b0;
  logic [1:0]    first_type = 2'b00;

  // Monitor
  initial begin
    logic [DW-1:0] exp_f;
    logic [31:0]   w;
    logic [1:0]    t;
    bit            snd;
    bit            upd;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        chk("rst_valid_o", valid_o_cast, 0);
        chk("rst_ready_o", ready_o, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_credit_cnt_mon", credit_cnt, CR);
        chk("rst_credit_err", credit_err, 0);
        m_cred = CR; m_err = 1'b0; m_pos = 0; exp_done = 1'b0;
        prev_hold = 1'b0; streak = 0; want_first = 1'b1;
      end else begin
        snd = valid_o_cast & ready_i_cast;
        upd = credit_upd;
        chk("credit_cnt", credit_cnt, m_cred);
        chk("credit_err", credit_err, m_err);
        chk("pkt_done", pkt_done, exp_done);
        if (m_cred == 0) chk("valid_at_zero_credit", valid_o_cast, 0);
        if (m_pos != 0) begin
          chk("valid_payld", valid_o_cast, valid_i & (m_cred != 0));
          chk("ready_payld", ready_o, snd);
        end else begin
          chk("ready_head", ready_o, 0);
        end
        if (prev_hold) begin
          chk("hold_valid", valid_o_cast, 1);
          chk("hold_data", data_o_cast, prev_data);
        end
        prev_hold = valid_o_cast & ~ready_i_cast;
        prev_data = data_o_cast;
        if (valid_i & ready_o) n_acc++;
        exp_done = 1'b0;
        if (snd) begin
          n_send++;
          streak++;
          if (want_first) begin
            first_type = data_o_cast[DW-1:DW-2];
            want_first = 1'b0;
          end
          if (m_pos == 0) begin
            exp_f = {FLIT_HEAD, {(PW-10){1'b0}}, SID};
            chk("flit", data_o_cast, exp_f);
          end else if (wq.size() == 0) begin
            chk("word_available", 0, 1);
          end else begin
            w = wq.pop_front();
            t = (m_pos == PL - 1) ? FLIT_TAIL : FLIT_BODY;
            exp_f = {t, w[PW-1:0]};
            chk("flit", data_o_cast, exp_f);
          end
          if (m_pos == PL - 1) begin
            n_tail++;
            tail_streak = streak;
            exp_done = 1'b1;
          end
          m_pos = (m_pos + 1) % PL;
        end else begin
          streak = 0;
        end
        if (upd && !snd && m_cred == CR) m_err = 1'b1;
        else m_cred = m_cred - int'(snd) + int'(upd);
      end
    end
  end

  // Driver
  int            words_left = 0;
  int            src_prob = 0;
  int            rdy_mode = 0;   // 0 always, 1 toggle, 2 random, 3 never
  int            upd_mode = 0;   // 0 none, 1 always, 2 echo sends, 3 random
  int            upd_shots = 0;
  bit            seq_mode = 1'b0;
  logic [PW-1:0] seq_val = '0;

  task automatic cyc();
    bit acc, snd;
    @(negedge clk);
    acc = valid_i & ready_o;
    snd = valid_o_cast & ready_i_cast;
    @(posedge clk);
    #1;
    if (acc) valid_i = 1'b0;
    if (!valid_i && words_left > 0 && $urandom_range(99) < src_prob) begin
      data_i = seq_mode ? seq_val : PW'($urandom);
      seq_val++;
      valid_i = 1'b1;
      words_left--;
      wq.push_back(32'(data_i));
    end
    case (rdy_mode)
      0:       ready_i_cast = 1'b1;
      1:       ready_i_cast = ~ready_i_cast;
      2:       ready_i_cast = 1'($urandom_range(1));
      default: ready_i_cast = 1'b0;
    endcase
    case (upd_mode)
      1:       credit_upd = 1'b1;
      2:       credit_upd = snd;
      3:       credit_upd = ($urandom_range(99) < 25);
      default: credit_upd = 1'b0;
    endcase
    if (upd_shots > 0) begin
      credit_upd = 1'b1;
      upd_shots--;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    valid_i = 1'b0;
    credit_upd = 1'b0;
    ready_i_cast = 1'b0;
    words_left = 0;
    upd_shots = 0;
    upd_mode = 0;
    wq.delete();
    repeat (2) @(negedge clk);
    chk("rst_credit_cnt", credit_cnt, CR);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int s0, a0, t0, k;
    #1;
    do_reset();

    // Single packet, words 1,2,3
    seq_mode = 1'b1; seq_val = 1; words_left = 3; src_prob = 100;
    rdy_mode = 0; upd_mode = 0;
    s0 = n_send; a0 = n_acc;
    run(10);
    chk("single_sends", n_send - s0, 4);
    chk("single_words", n_acc - a0, 3);
    chk("single_consecutive", tail_streak, 4);
    chk("single_credit_cnt", credit_cnt, 0);

    // Credit stall: next packet waits for a credit
    words_left = 3;
    s0 = n_send;
    run(5);
    chk("stall_no_send", n_send - s0, 0);
    upd_shots = 1;
    s0 = n_send;
    run(6);
    chk("stall_one_flit", n_send - s0, 1);
    chk("stall_credit_cnt", credit_cnt, 0);

    // Simultaneous send and credit return at count 2
    do_reset();
    seq_mode = 1'b0; words_left = 1_000_000; src_prob = 100; rdy_mode = 0;
    k = 0;
    while (m_cred != 2 && k < 20) begin cyc(); k++; end
    chk("sim_reach_two", m_cred, 2);
    upd_mode = 1; credit_upd = 1'b1;
    run(3);
    chk("sim_credit_hold", credit_cnt, 2);
    rdy_mode = 3; ready_i_cast = 1'b0;
    run(4);
    chk("sim_credit_sat", credit_cnt, 4);
    chk("sim_credit_err", credit_err, 1);

    // Backpressure: ready toggles over two packets
    do_reset();
    words_left = 6; src_prob = 100; rdy_mode = 1; upd_mode = 2;
    s0 = n_send; a0 = n_acc; t0 = n_tail; k = 0;
    while (n_tail - t0 < 2 && k < 100) begin cyc(); k++; end
    chk("bp_tails", n_tail - t0, 2);
    chk("bp_flits", n_send - s0, 8);
    chk("bp_words", n_acc - a0, 6);

    // Back-to-back packets at full rate
    do_reset();
    words_left = 1_000_000; src_prob = 100; rdy_mode = 0; upd_mode = 1;
    run(10);
    s0 = n_send; t0 = n_tail;
    run(40);
    chk("b2b_throughput", n_send - s0, 40);
    chk("b2b_packets", n_tail - t0, 10);

    // Reset in the middle of a packet
    do_reset();
    seq_mode = 1'b1; seq_val = 1; words_left = 1_000_000; src_prob = 100;
    rdy_mode = 0; upd_mode = 0;
    k = 0;
    while (m_pos != 2 && k < 50) begin cyc(); k++; end
    chk("mid_reach_body1", m_pos, 2);
    do_reset();
    seq_val = 1; words_left = 3; src_prob = 100; rdy_mode = 0;
    run(12);
    chk("mid_first_head", first_type, FLIT_HEAD);

    // Randomised traffic
    do_reset();
    seq_mode = 1'b0; words_left = 1_000_000; src_prob = 70;
    rdy_mode = 2; upd_mode = 3;
    run(600);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
